pipe_stage_skid: RTL and testbench

Parametrised pipeline stage register carrying a PC/instruction pair between two processor stages with a valid/ready handshake, synchronous flush, NOP bubble insertion and an optional two-entry skid buffer. It generalises the fixed 32-bit IF/ID latch into a reusable stage that can sit between any pair of pipeline stages (IF/ID, ID/EX, …). Backpressure propagates through `in_ready` and never loses or duplicates a beat. A saturating starvation counter supports performance debug.

---
 rtl/pipe_stage_skid.sv | 159 +++++++++++++++
 tb/tb_pipe_stage_skid.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: PC/instruction pipeline stage register with valid/ready handshake,
// synchronous flush, NOP bubble insertion and a saturating starvation counter.
//
// Build option: define PIPE_SKID_EN for a two-entry skid buffer with a registered in_ready.
// Without it the stage is a single register with a combinational in_ready.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   flush             squash all held beats (and any beat accepted this cycle)
//   in_valid/in_ready upstream handshake, in_pc/in_ins upstream payload
//   out_valid/out_ready downstream handshake, out_pc/out_ins held payload
//   out_ins           forced to NOP_INS while out_valid=0
//   bubble_cnt        saturating count of cycles with out_ready=1 and out_valid=0
module pipe_stage_skid #(
  parameter int unsigned      PC_W    = 32,
  parameter int unsigned      INS_W   = 32,
  parameter logic [INS_W-1:0] NOP_INS = {INS_W{1'b0}},
  parameter int unsigned      CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PC_W-1:0]  in_pc,
  input  logic [INS_W-1:0] in_ins,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [INS_W-1:0] out_ins,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             in_fire;
  logic             out_fire;
  logic             main_valid_q, main_valid_d;
  logic [PC_W-1:0]  main_pc_q, main_pc_d;
  logic [INS_W-1:0] main_ins_q, main_ins_d;
  logic [CNT_W-1:0] bubble_q, bubble_d;

  assign in_fire    = in_valid & in_ready;
  assign out_fire   = main_valid_q & out_ready;
  assign out_valid  = main_valid_q;
  assign out_pc     = main_pc_q;
  assign out_ins    = main_valid_q ? main_ins_q : NOP_INS;
  assign bubble_cnt = bubble_q;

`ifdef PIPE_SKID_EN

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic [PC_W-1:0]  skid_pc_q, skid_pc_d;
  logic [INS_W-1:0] skid_ins_q, skid_ins_d;

  // Registered so that out_ready has no combinational path to in_ready.
  assign in_ready = in_ready_q;

  always_comb begin
    state_d    = state_q;
    main_pc_d  = main_pc_q;
    main_ins_d = main_ins_q;
    skid_pc_d  = skid_pc_q;
    skid_ins_d = skid_ins_q;
    if (flush) begin
      state_d = StEmpty;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            state_d    = StOne;
            main_pc_d  = in_pc;
            main_ins_d = in_ins;
          end
        end
        StOne: begin
          if (in_fire && out_fire) begin
            main_pc_d  = in_pc;
            main_ins_d = in_ins;
          end else if (in_fire) begin
            state_d    = StFull;
            skid_pc_d  = in_pc;
            skid_ins_d = in_ins;
          end else if (out_fire) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          // in_ready is low here, so only a drain can happen.
          if (out_fire) begin
            state_d    = StOne;
            main_pc_d  = skid_pc_q;
            main_ins_d = skid_ins_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
    main_valid_d = (state_d != StEmpty);
    in_ready_d   = (state_d != StFull);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StEmpty;
      in_ready_q <= 1'b1;
      skid_pc_q  <= '0;
      skid_ins_q <= NOP_INS;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      skid_pc_q  <= skid_pc_d;
      skid_ins_q <= skid_ins_d;
    end
  end

`else

  assign in_ready = out_ready | ~main_valid_q;

  always_comb begin
    main_pc_d    = main_pc_q;
    main_ins_d   = main_ins_q;
    main_valid_d = in_fire | (main_valid_q & ~out_ready);
    if (flush) begin
      // A beat accepted alongside a flush is dropped; out_pc keeps its old value.
      main_valid_d = 1'b0;
    end else if (in_fire) begin
      main_pc_d  = in_pc;
      main_ins_d = in_ins;
    end
  end

`endif

  // Starvation counter: saturates, untouched by flush.
  always_comb begin
    bubble_d = bubble_q;
    if (out_ready && !main_valid_q && (bubble_q != {CNT_W{1'b1}})) begin
      bubble_d = bubble_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_pc_q    <= '0;
      main_ins_q   <= NOP_INS;
      bubble_q     <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_pc_q    <= main_pc_d;
      main_ins_q   <= main_ins_d;
      bubble_q     <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_pc, in_ins;
  logic        in_ready, out_valid;
  logic [31:0] out_pc, out_ins;
  logic [15:0] bubble_cnt;
  logic        in_ready4, out_valid4;
  logic [31:0] out_pc4, out_ins4;
  logic [3:0]  bubble_cnt4;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_stage_skid dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_ins     (in_ins),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pc     (out_pc),
    .out_ins    (out_ins),
    .bubble_cnt (bubble_cnt)
  );

  pipe_stage_skid #(.CNT_W(4)) dut4 (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready4),
    .in_pc      (in_pc),
    .in_ins     (in_ins),
    .out_valid  (out_valid4),
    .out_ready  (out_ready),
    .out_pc     (out_pc4),
    .out_ins    (out_ins4),
    .bubble_cnt (bubble_cnt4)
  );

  function automatic logic [31:0] ins_of(input logic [31:0] pc);
    return 32'hA500_0000 ^ pc;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] pc);
    in_valid = 1'b1;
    in_pc    = pc;
    in_ins   = ins_of(pc);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_ins = '0;
    tick(); tick();
    check("rst_valid", out_valid, 0);
    check("rst_pc", out_pc, 0);
    check("rst_ins", out_ins, 0);
    check("rst_cnt", bubble_cnt, 0);
    check("rst_ready", in_ready, 1);
    check("rst_cnt4", bubble_cnt4, 0);

    // Idle with downstream ready: five bubbles.
    rst = 1'b0; out_ready = 1'b1;
    repeat (5) tick();
    check("idle_valid", out_valid, 0);
    check("idle_ins", out_ins, 0);
    check("idle_cnt", bubble_cnt, 5);

    // Back-to-back stream.
    send(32'h100); tick();
    check("s0_valid", out_valid, 1);
    check("s0_pc", out_pc, 32'h100);
    check("s0_ins", out_ins, ins_of(32'h100));
    send(32'h104); tick();
    check("s1_pc", out_pc, 32'h104);
    check("s1_ins", out_ins, ins_of(32'h104));
    send(32'h108); tick();
    check("s2_pc", out_pc, 32'h108);
    check("s2_valid", out_valid, 1);
    in_valid = 1'b0; tick();
    check("s_drain_valid", out_valid, 0);
    check("s_drain_ins", out_ins, 0);
    check("s_cnt", bubble_cnt, 6);

    // Backpressure: two beats under stall, then release.
    out_ready = 1'b0;
    send(32'h200); tick();
    check("k0_pc", out_pc, 32'h200);
`ifdef PIPE_SKID_EN
    check("k0_ready", in_ready, 1);
`else
    check("k0_ready", in_ready, 0);
`endif
    send(32'h204); tick();
    check("k1_ready", in_ready, 0);
    check("k1_pc", out_pc, 32'h200);
    out_ready = 1'b1;
`ifdef PIPE_SKID_EN
    in_valid = 1'b0; #1;
    check("k1_ready_reg", in_ready, 0);
`else
    #1;
    check("k1_ready_comb", in_ready, 1);
`endif
    tick();
    in_valid = 1'b0;
    check("k2_valid", out_valid, 1);
    check("k2_pc", out_pc, 32'h204);
    check("k2_ins", out_ins, ins_of(32'h204));
    check("k2_ready", in_ready, 1);
    tick();
    check("k3_valid", out_valid, 0);
    check("k3_cnt", bubble_cnt, 6);

    // Flush while stalled/full, then flush discarding an accepted beat.
    out_ready = 1'b0;
    send(32'h310); tick();
    send(32'h314); tick();
    check("f0_ready", in_ready, 0);
    check("f0_pc", out_pc, 32'h310);
    send(32'h300); flush = 1'b1; tick();
    check("f1_valid", out_valid, 0);
    check("f1_ins", out_ins, 0);
    check("f1_pc_hold", out_pc, 32'h310);
    check("f1_ready", in_ready, 1);
    tick();
    check("f2_valid", out_valid, 0);
    check("f2_pc_hold", out_pc, 32'h310);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; tick();
    check("f3_valid", out_valid, 0);
    check("f3_cnt", bubble_cnt, 7);

    // Reset together with flush mid-stream.
    send(32'h400); tick();
    check("r0_pc", out_pc, 32'h400);
    check("r0_cnt", bubble_cnt, 8);
    send(32'h404); rst = 1'b1; flush = 1'b1; tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; #1;
    check("r1_valid", out_valid, 0);
    check("r1_pc", out_pc, 0);
    check("r1_ins", out_ins, 0);
    check("r1_cnt", bubble_cnt, 0);
    check("r1_ready", in_ready, 1);

    // Starve for 20 cycles: narrow counter saturates.
    repeat (20) tick();
    check("sat_cnt16", bubble_cnt, 20);
    check("sat_cnt4", bubble_cnt4, 15);
    check("sat_valid4", out_valid4, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
